// File: rtl/pe_pkg.sv
// Shared types and constants for the PE datapath and its dot-product controller.
package pe_pkg;

  localparam int PE_LANES = 8;
  localparam int PE_LAT   = 4;

  typedef logic signed [7:0]  mult_t;
  typedef logic signed [24:0] psum_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/pe_vld_pipe.sv
// Fixed-depth 1-bit valid delay line; follows each issued beat through the PE.
module pe_vld_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign vld_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_dot_ctrl.sv
// Dot-product sequencer for one 8-lane PE: streams N operand chunks, accumulates psums,
// returns one result. Define PE_DOT_SAT_EN to saturate the result instead of wrapping it.
module pe_dot_ctrl
  import pe_pkg::*;
#(
  parameter int PE_LAT_CYC = PE_LAT,
  parameter int MAX_CHUNKS = 16,
  parameter int OUT_W      = 24,
  parameter int CW         = $clog2(MAX_CHUNKS + 1),
  parameter int ACC_W      = 25 + $clog2(MAX_CHUNKS) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [CW-1:0]           cfg_chunks,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  mult_t [PE_LANES-1:0]    in_ifm,
  input  mult_t [PE_LANES-1:0]    in_wgt,
  output mult_t [PE_LANES-1:0]    pe_ifm,
  output mult_t [PE_LANES-1:0]    pe_wgt,
  input  psum_t                   pe_psum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output ctrl_state_e             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready and out_valid are pure functions of registered state (no combinational paths).

`ifdef PE_DOT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  function automatic logic signed [OUT_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
`ifdef PE_DOT_SAT_EN
    if (a > ACC_MAX) begin
      reduce_acc = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (a < ACC_MIN) begin
      reduce_acc = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      reduce_acc = a[OUT_W-1:0];
    end
`else
    reduce_acc = a[OUT_W-1:0];
`endif
  endfunction

  ctrl_state_e              state_q, state_d;
  logic [CW-1:0]            chunks_q, chunks_d;
  logic [CW-1:0]            issued_q, issued_d;
  logic [CW-1:0]            done_q, done_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  mult_t [PE_LANES-1:0]     pe_ifm_q, pe_wgt_q;

  logic                     fire;
  logic                     psum_vld;
  logic signed [ACC_W-1:0]  psum_ext;
  logic [CW-1:0]            cfg_clamped;

  assign in_ready    = (state_q == RUN) && (issued_q < chunks_q);
  assign fire        = in_valid && in_ready;
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == OUT);
  assign out_data    = out_data_q;
  assign pe_ifm      = pe_ifm_q;
  assign pe_wgt      = pe_wgt_q;
  assign dbg_state_o = state_q;
  assign psum_ext    = ACC_W'(pe_psum);
  assign cfg_clamped = (cfg_chunks > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : cfg_chunks;

  // Tail of this line is high exactly in the cycle the matching psum sits on pe_psum.
  pe_vld_pipe #(
    .DEPTH(PE_LAT_CYC + 1)
  ) u_vld_pipe (
    .clk_i (clk),
    .rstn_i(rstn),
    .vld_i (fire),
    .vld_o (psum_vld)
  );

  always_comb begin
    state_d    = state_q;
    chunks_d   = chunks_q;
    issued_d   = issued_q;
    done_d     = done_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;

    if (psum_vld) begin
      acc_d  = acc_q + psum_ext;
      done_d = done_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          chunks_d = cfg_clamped;
          issued_d = '0;
          done_d   = '0;
          acc_d    = '0;
          if (cfg_clamped == '0) begin
            out_data_d = '0;
            state_d    = OUT;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          issued_d = issued_q + CW'(1);
          if (issued_q + CW'(1) == chunks_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave only once the final beat's psum is folded into acc_d this cycle.
        if (psum_vld && (done_q + CW'(1) == chunks_q)) begin
          out_data_d = reduce_acc(acc_d);
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      chunks_q   <= '0;
      issued_q   <= '0;
      done_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      pe_ifm_q   <= '0;
      pe_wgt_q   <= '0;
    end else begin
      state_q    <= state_d;
      chunks_q   <= chunks_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      pe_ifm_q   <= fire ? in_ifm : '0;
      pe_wgt_q   <= fire ? in_wgt : '0;
    end
  end

endmodule

// File: tb/tb_pe_dot_ctrl.sv
// Directed bench for pe_dot_ctrl with a behavioural 4-cycle PE model driving pe_psum.
module tb_pe_dot_ctrl;
  import pe_pkg::*;

  localparam int MAX_CHUNKS = 16;
  localparam int OUT_W      = 20;
  localparam int CW         = 5;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    start;
  logic [CW-1:0]           cfg_chunks;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  mult_t [PE_LANES-1:0]    in_ifm;
  mult_t [PE_LANES-1:0]    in_wgt;
  mult_t [PE_LANES-1:0]    pe_ifm;
  mult_t [PE_LANES-1:0]    pe_wgt;
  psum_t                   pe_psum;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  ctrl_state_e             dbg_state;

  int cmp_cnt = 0;
  int err_cnt = 0;

  pe_dot_ctrl #(
    .MAX_CHUNKS(MAX_CHUNKS),
    .OUT_W     (OUT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_chunks (cfg_chunks),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ifm     (in_ifm),
    .in_wgt     (in_wgt),
    .pe_ifm     (pe_ifm),
    .pe_wgt     (pe_wgt),
    .pe_psum    (pe_psum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // PE model: products of the registered operands, psum valid 4 edges later
  int    pe_dot;
  psum_t pe_s1 = '0, pe_s2 = '0, pe_s3 = '0, pe_s4 = '0;

  always_comb begin
    pe_dot = 0;
    for (int i = 0; i < PE_LANES; i++) begin
      pe_dot = pe_dot + int'(pe_ifm[i]) * int'(pe_wgt[i]);
    end
  end

  always @(posedge clk) begin
    pe_s1 <= psum_t'(pe_dot);
    pe_s2 <= pe_s1;
    pe_s3 <= pe_s2;
    pe_s4 <= pe_s3;
  end

  assign pe_psum = pe_s4;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int n);
    start      = 1'b1;
    cfg_chunks = CW'(n);
    tick();
    start      = 1'b0;
  endtask

  task automatic set_ops(input int a, input int w);
    for (int i = 0; i < PE_LANES; i++) begin
      in_ifm[i] = 8'(a);
      in_wgt[i] = 8'(w);
    end
  endtask

  // waits = cycles spent before the beat fired; 30 means it never fired
  task automatic fire_beat(input int a, input int w, output int waits);
    set_ops(a, w);
    in_valid = 1'b1;
    waits    = 30;
    for (int k = 0; k < 30; k++) begin
      if (in_ready) begin
        waits = k;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int w;
  int e;
  int nfire;
  logic signed [31:0] exp_sat;

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    cfg_chunks = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    set_ops(0, 0);
    repeat (2) tick();

    check("rst_busy",      32'(busy), 0);
    check("rst_in_ready",  32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_pe_ifm",    32'(|pe_ifm), 0);
    check("rst_pe_wgt",    32'(|pe_wgt), 0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));
    rstn = 1'b1;
    tick();

    // 1: 3 back-to-back chunks of 1*2 -> 48, result 5 edges after the last fire
    start_job(3);
    check("t1_busy", 32'(busy), 1);
    fire_beat(1, 2, w);
    check("t1_fire0_wait", w, 0);
    check("t1_pe_ifm", 32'(pe_ifm[7]), 1);
    check("t1_pe_wgt", 32'(pe_wgt[0]), 2);
    fire_beat(1, 2, w);
    check("t1_fire1_wait", w, 0);
    fire_beat(1, 2, w);
    check("t1_fire2_wait", w, 0);
    wait_out(e);
    check("t1_latency", e, 5);
    check("t1_data", 32'(out_data), 48);
    check("t1_pe_idle", 32'(|pe_ifm), 0);
    take_out();
    check("t1_done_valid", 32'(out_valid), 0);
    check("t1_done_busy", 32'(busy), 0);

    // 2: two chunks with a 4-cycle valid gap -> -120 + -56 = -176
    start_job(2);
    fire_beat(-3, 5, w);
    check("t2_fire0_wait", w, 0);
    repeat (4) tick();
    check("t2_gap_ready", 32'(in_ready), 1);
    fire_beat(7, -1, w);
    check("t2_fire1_wait", w, 0);
    check("t2_drain_state", 32'(dbg_state), 32'(DRAIN));
    check("t2_drain_ready0", 32'(in_ready), 0);
    in_valid = 1'b1;
    tick();
    check("t2_drain_ready1", 32'(in_ready), 0);
    in_valid = 1'b0;
    wait_out(e);
    check("t2_data", 32'(out_data), -176);
    take_out();

    // 3: zero chunks -> immediate result 0, no PE traffic
    start_job(0);
    check("t3_valid", 32'(out_valid), 1);
    check("t3_data", 32'(out_data), 0);
    check("t3_state", 32'(dbg_state), 32'(OUT));
    check("t3_pe_ifm", 32'(|pe_ifm), 0);
    take_out();
    check("t3_pe_wgt", 32'(|pe_wgt), 0);
    check("t3_busy", 32'(busy), 0);

    // 4: 16 chunks of -128*-128 -> acc = 2^21, reduced to 20 bits
`ifdef PE_DOT_SAT_EN
    exp_sat = 524287;
`else
    exp_sat = 0;
`endif
    start_job(16);
    nfire = 0;
    for (int b = 0; b < 16; b++) begin
      fire_beat(-128, -128, w);
      if (w < 30) nfire++;
    end
    check("t4_fires", nfire, 16);
    wait_out(e);
    check("t4_latency", e, 5);
    check("t4_data", 32'(out_data), exp_sat);
    take_out();

    // 5: result held under backpressure, start during OUT ignored
    start_job(1);
    fire_beat(2, 3, w);
    wait_out(e);
    check("t5_data", 32'(out_data), 48);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        start      = 1'b1;
        cfg_chunks = CW'(5);
      end
      tick();
      start = 1'b0;
      check("t5_hold_data", 32'(out_data), 48);
      check("t5_hold_valid", 32'(out_valid), 1);
      check("t5_hold_busy", 32'(busy), 1);
    end
    take_out();
    check("t5_done_valid", 32'(out_valid), 0);
    check("t5_done_busy", 32'(busy), 0);
    tick();
    check("t5_no_restart", 32'(busy), 0);

    // 6: reset after 2 of 4 beats, then a clean 1-chunk job
    start_job(4);
    fire_beat(3, 3, w);
    fire_beat(3, 3, w);
    check("t6_pre_rst_ifm", 32'(pe_ifm[0]), 3);
    rstn = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    check("t6_rst_in_ready", 32'(in_ready), 0);
    check("t6_rst_out_valid", 32'(out_valid), 0);
    check("t6_rst_out_data", 32'(out_data), 0);
    check("t6_rst_pe_ifm", 32'(|pe_ifm), 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    start_job(1);
    fire_beat(1, 1, w);
    check("t6_fire_wait", w, 0);
    wait_out(e);
    check("t6_latency", e, 5);
    check("t6_data", 32'(out_data), 8);
    take_out();

    // 7: cfg_chunks above MAX_CHUNKS clamps to 16
    start_job(31);
    for (int b = 0; b < 16; b++) begin
      fire_beat(1, 1, w);
    end
    check("t7_clamp_ready", 32'(in_ready), 0);
    check("t7_clamp_state", 32'(dbg_state), 32'(DRAIN));
    wait_out(e);
    check("t7_data", 32'(out_data), 128);
    take_out();
    check("t7_done_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
